// File: rtl/freq_pkg.sv
// Shared constants for the frequency meter / generator pair, plus the
// frequency clamp used when a new setting is captured.
package freq_pkg;

   localparam int unsigned CLK_HZ   = 125000000;
   localparam int          FREQ_W   = 20;
   localparam int          ACC_W    = 28;
   localparam int unsigned MAX_FREQ = CLK_HZ / 4;

   // Clamp a requested frequency to the highest one the accumulator can produce.
   function automatic int unsigned sat_freq(input int unsigned f, input int unsigned max_f);
      return (f > max_f) ? max_f : f;
   endfunction

endpackage

// File: rtl/freq_gen_if.sv
// Control/status bundle of the frequency generator.
//
// Handshake: there is no valid/ready pair. load is a single-cycle strobe that
// is always accepted; freq_set is sampled only in a cycle where load is high.
// busy reports that a captured value has not yet reached freq_cur; it never
// back-pressures load (a later load simply replaces the pending value).
interface freq_gen_if #(
   parameter int FREQ_W = freq_pkg::FREQ_W
);
   logic              en;
   logic              load;
   logic [FREQ_W-1:0] freq_set;
   logic              busy;
   logic [FREQ_W-1:0] freq_cur;
   logic              wave_out;
   logic              rise_stb;

   modport master (
      output en, load, freq_set,
      input  busy, freq_cur, wave_out, rise_stb
   );

   modport slave (
      input  en, load, freq_set,
      output busy, freq_cur, wave_out, rise_stb
   );
endinterface

// File: rtl/freq_gen_acc.sv
// Fractional phase accumulator: adds 2*freq each cycle, wraps at CLK_HZ and
// toggles the output on every wrap. rise_now flags the edge at which the
// output is about to go 0->1, so the owner can retune on that boundary.
module freq_gen_acc #(
   parameter int unsigned CLK_HZ = freq_pkg::CLK_HZ,
   parameter int          FREQ_W = freq_pkg::FREQ_W,
   parameter int          ACC_W  = freq_pkg::ACC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic [FREQ_W-1:0] freq,
   output logic              wave_out,
   output logic              rise_stb,
   output logic              rise_now
);

   localparam logic [ACC_W-1:0] CLK_C = ACC_W'(CLK_HZ);

   logic [ACC_W-1:0] acc_q, acc_d, sum;
   logic             wave_q, wave_d;
   logic             rise_q, rise_d;

   // Next accumulator, wave and rise strobe; everything collapses to zero when idle.
   always_comb begin
      sum    = acc_q + ACC_W'({freq, 1'b0});
      acc_d  = '0;
      wave_d = 1'b0;
      rise_d = 1'b0;
      if (run) begin
         if (sum >= CLK_C) begin
            acc_d  = sum - CLK_C;
            wave_d = ~wave_q;
            rise_d = ~wave_q;
         end else begin
            acc_d  = sum;
            wave_d = wave_q;
         end
      end
   end

   // Accumulator and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         wave_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         wave_q <= wave_d;
         rise_q <= rise_d;
      end
   end

   assign wave_out = wave_q;
   assign rise_stb = rise_q;
   assign rise_now = rise_d;

endmodule

// File: rtl/freq_gen.sv
// Programmable 50% square-wave source. Holds the load/pending/apply logic;
// a new frequency takes effect immediately when idle, or exactly on the
// 0->1 edge when running, so the waveform never shows a runt pulse.
module freq_gen #(
   parameter int unsigned CLK_HZ = freq_pkg::CLK_HZ,
   parameter int          FREQ_W = freq_pkg::FREQ_W,
   parameter int          ACC_W  = freq_pkg::ACC_W
) (
   input logic      clk,
   input logic      rst_n,
   freq_gen_if.slave bus
);
   import freq_pkg::*;

   localparam int unsigned MAX_F = CLK_HZ / 4;

   logic [FREQ_W-1:0] freq_cur_q, freq_cur_d;
   logic [FREQ_W-1:0] freq_next_q, freq_next_d;
   logic              busy_q, busy_d;
   logic              run, apply, rise_now;

   assign run = bus.en && (freq_cur_q != '0);

   // Capture on load; apply when idle or on the rising-edge boundary while running.
   always_comb begin
      apply       = busy_q && (!run || rise_now);
      freq_cur_d  = apply ? freq_next_q : freq_cur_q;
      freq_next_d = freq_next_q;
      busy_d      = busy_q;
      if (apply) begin
         busy_d = 1'b0;
      end
      if (bus.load) begin
         freq_next_d = FREQ_W'(sat_freq(32'(bus.freq_set), MAX_F));
         busy_d      = 1'b1;
      end
   end

   // Frequency setting registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freq_cur_q  <= '0;
         freq_next_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         freq_cur_q  <= freq_cur_d;
         freq_next_q <= freq_next_d;
         busy_q      <= busy_d;
      end
   end

   freq_gen_acc #(
      .CLK_HZ (CLK_HZ),
      .FREQ_W (FREQ_W),
      .ACC_W  (ACC_W)
   ) u_acc (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .freq     (freq_cur_q),
      .wave_out (bus.wave_out),
      .rise_stb (bus.rise_stb),
      .rise_now (rise_now)
   );

   assign bus.busy     = busy_q;
   assign bus.freq_cur = freq_cur_q;

endmodule

// File: tb/tb_freq_gen.sv
// Directed bench: one generator at the default 125 MHz clock, one built for
// CLK_HZ=1000 so period and retune cases stay short.
module tb_freq_gen;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   freq_gen_if #(.FREQ_W(20)) bus_d ();
   freq_gen_if #(.FREQ_W(20)) bus_s ();

   freq_gen u_def (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_d.slave)
   );

   freq_gen #(.CLK_HZ(1000)) u_small (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_s.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- access helpers (sel 0 = default, 1 = small) ----------------
   function automatic logic wave_of(input bit sel);
      return sel ? bus_s.wave_out : bus_d.wave_out;
   endfunction
   function automatic logic rise_of(input bit sel);
      return sel ? bus_s.rise_stb : bus_d.rise_stb;
   endfunction
   function automatic logic busy_of(input bit sel);
      return sel ? bus_s.busy : bus_d.busy;
   endfunction
   function automatic logic [19:0] cur_of(input bit sel);
      return sel ? bus_s.freq_cur : bus_d.freq_cur;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // advance n rising edges, then settle 1 ns past the edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_load(input bit sel, input logic [19:0] val);
      if (sel) begin
         bus_s.load = 1'b1; bus_s.freq_set = val;
      end else begin
         bus_d.load = 1'b1; bus_d.freq_set = val;
      end
      step(1);
      bus_s.load = 1'b0;
      bus_d.load = 1'b0;
   endtask

   // step until rise_stb is seen; n = number of edges taken
   task automatic wait_rise(input bit sel, output int n);
      n = 0;
      do begin
         step(1);
         n++;
      end while (!rise_of(sel) && n < 1000);
      chk("rise_seen", {31'd0, rise_of(sel)}, 32'd1);
   endtask

   // from a rise cycle, count high cycles, low cycles and rise strobes of one period
   task automatic measure(input bit sel, output int h, output int l, output int r);
      h = 0; l = 0; r = 0;
      while (wave_of(sel) && h < 1000) begin
         if (rise_of(sel)) r++;
         h++;
         step(1);
      end
      while (!wave_of(sel) && l < 1000) begin
         if (rise_of(sel)) r++;
         l++;
         step(1);
      end
   endtask

   initial begin
      int k, n, h, l, r;
      rst_n = 1'b0;
      bus_d.en = 1'b0; bus_d.load = 1'b0; bus_d.freq_set = '0;
      bus_s.en = 1'b0; bus_s.load = 1'b0; bus_s.freq_set = '0;

      // ---- reset state ----
      #23;
      chk("rst_wave", {31'd0, bus_d.wave_out}, 32'd0);
      chk("rst_rise", {31'd0, bus_d.rise_stb}, 32'd0);
      chk("rst_busy", {31'd0, bus_d.busy}, 32'd0);
      chk("rst_cur",  {12'd0, bus_d.freq_cur}, 32'd0);
      step(1);
      rst_n = 1'b1;

      // ---- 1: enabled with freq_cur = 0 stays idle ----
      bus_d.en = 1'b1;
      bus_s.en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         step(1);
         chk("idle_wave", {31'd0, bus_d.wave_out}, 32'd0);
         chk("idle_rise", {31'd0, bus_d.rise_stb}, 32'd0);
         chk("idle_busy", {31'd0, bus_d.busy}, 32'd0);
         chk("idle_wave_s", {31'd0, bus_s.wave_out}, 32'd0);
      end

      // ---- 2: 500 kHz at 125 MHz ----
      pulse_load(0, 20'd500000);
      chk("t2_busy", {31'd0, busy_of(0)}, 32'd1);
      chk("t2_cur_pend", {12'd0, cur_of(0)}, 32'd0);
      step(1);
      chk("t2_busy_clr", {31'd0, busy_of(0)}, 32'd0);
      chk("t2_cur", {12'd0, cur_of(0)}, 32'd500000);
      k = 0;
      do begin
         step(1);
         k++;
      end while (!wave_of(0) && k < 300);
      chk("t2_first_rise", k, 32'd125);
      chk("t2_first_stb", {31'd0, rise_of(0)}, 32'd1);
      measure(0, h, l, r);
      chk("t2_high", h, 32'd125);
      chk("t2_low", l, 32'd125);
      chk("t2_stb_cnt", r, 32'd1);

      // ---- 3: retune to 1 MHz at the boundary ----
      pulse_load(0, 20'd1000000);
      chk("t3_busy", {31'd0, busy_of(0)}, 32'd1);
      chk("t3_cur_old", {12'd0, cur_of(0)}, 32'd500000);
      wait_rise(0, n);
      chk("t3_rise_at", n, 32'd249);
      chk("t3_cur", {12'd0, cur_of(0)}, 32'd1000000);
      chk("t3_busy_clr", {31'd0, busy_of(0)}, 32'd0);
      for (int p = 0; p < 2; p++) begin
         measure(0, h, l, r);
         chk("t3_period", h + l, 32'd125);
         chk("t3_halves", {31'd0, (h == 62 || h == 63)}, 32'd1);
         chk("t3_stb_cnt", r, 32'd1);
      end

      // ---- 4: CLK_HZ=1000, run at 100, retune to 50 mid-high-half ----
      pulse_load(1, 20'd100);
      chk("t4_busy", {31'd0, busy_of(1)}, 32'd1);
      step(1);
      chk("t4_cur100", {12'd0, cur_of(1)}, 32'd100);
      wait_rise(1, n);
      chk("t4_first_rise", n, 32'd5);
      measure(1, h, l, r);
      chk("t4_high100", h, 32'd5);
      chk("t4_low100", l, 32'd5);
      step(2);
      chk("t4_mid_high", {31'd0, wave_of(1)}, 32'd1);
      pulse_load(1, 20'd50);
      chk("t4_busy_pend", {31'd0, busy_of(1)}, 32'd1);
      chk("t4_cur_hold", {12'd0, cur_of(1)}, 32'd100);
      wait_rise(1, n);
      chk("t4_rise_at", n, 32'd7);
      chk("t4_cur50", {12'd0, cur_of(1)}, 32'd50);
      chk("t4_busy_clr", {31'd0, busy_of(1)}, 32'd0);
      measure(1, h, l, r);
      chk("t4_high50", h, 32'd10);
      chk("t4_low50", l, 32'd10);
      chk("t4_stb_cnt", r, 32'd1);

      // ---- 5: latest load wins; load in the apply cycle ----
      pulse_load(1, 20'd100);
      chk("t5_busy_a", {31'd0, busy_of(1)}, 32'd1);
      step(1);
      pulse_load(1, 20'd200);
      chk("t5_cur_hold", {12'd0, cur_of(1)}, 32'd50);
      wait_rise(1, n);
      chk("t5_rise_at", n, 32'd17);
      chk("t5_cur200", {12'd0, cur_of(1)}, 32'd200);
      chk("t5_busy_clr", {31'd0, busy_of(1)}, 32'd0);
      pulse_load(1, 20'd100);
      step(3);
      pulse_load(1, 20'd50);
      chk("t5_apply_rise", {31'd0, rise_of(1)}, 32'd1);
      chk("t5_cur100", {12'd0, cur_of(1)}, 32'd100);
      chk("t5_busy_kept", {31'd0, busy_of(1)}, 32'd1);
      wait_rise(1, n);
      chk("t5_rise2_at", n, 32'd10);
      chk("t5_cur50", {12'd0, cur_of(1)}, 32'd50);
      chk("t5_busy_clr2", {31'd0, busy_of(1)}, 32'd0);

      // ---- en dropped together with a load ----
      bus_s.en = 1'b0;
      pulse_load(1, 20'd125);
      chk("dis_wave", {31'd0, wave_of(1)}, 32'd0);
      chk("dis_busy", {31'd0, busy_of(1)}, 32'd1);
      step(1);
      chk("dis_cur", {12'd0, cur_of(1)}, 32'd125);
      chk("dis_busy_clr", {31'd0, busy_of(1)}, 32'd0);
      bus_s.en = 1'b1;
      wait_rise(1, n);
      chk("t125_rise_at", n, 32'd4);

      // ---- 6: async reset mid-high-half, then clamped load ----
      step(1);
      chk("t6_high", {31'd0, wave_of(1)}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_wave", {31'd0, wave_of(1)}, 32'd0);
      chk("t6_async_cur", {12'd0, cur_of(1)}, 32'd0);
      chk("t6_async_busy", {31'd0, busy_of(1)}, 32'd0);
      chk("t6_async_wave_d", {31'd0, wave_of(0)}, 32'd0);
      step(2);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk("t6_idle_wave", {31'd0, wave_of(1)}, 32'd0);
      end
      pulse_load(1, 20'd400);
      chk("t6_busy", {31'd0, busy_of(1)}, 32'd1);
      step(1);
      chk("t6_clamp", {12'd0, cur_of(1)}, 32'd250);
      wait_rise(1, n);
      chk("t6_rise_at", n, 32'd2);
      measure(1, h, l, r);
      chk("t6_high", h, 32'd2);
      chk("t6_low", l, 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
